// File: rtl/frame_buffer_ctrl_if.sv
// frame_buffer_ctrl_if: pixel bus between the load/store unit (master) and the frame buffer (slave).
//   we/x_write/y_write/write_value : write request
//   re/x_read/y_read               : read request
//   read_value/read_valid          : registered read response, one cycle after re
//   fill_start/fill_value          : bulk clear-to-colour request
//   busy/wr_error                  : fill engine active / rejected-write pulse
interface frame_buffer_ctrl_if #(
    parameter int XBits     = 9,
    parameter int YBits     = 8,
    parameter int ColorBits = 3
);
    logic                 we;
    logic [XBits-1:0]     x_write;
    logic [YBits-1:0]     y_write;
    logic [ColorBits-1:0] write_value;
    logic                 re;
    logic [XBits-1:0]     x_read;
    logic [YBits-1:0]     y_read;
    logic [ColorBits-1:0] read_value;
    logic                 read_valid;
    logic                 fill_start;
    logic [ColorBits-1:0] fill_value;
    logic                 busy;
    logic                 wr_error;

    modport master (
        output we, x_write, y_write, write_value, re, x_read, y_read, fill_start, fill_value,
        input  read_value, read_valid, busy, wr_error
    );

    modport slave (
        input  we, x_write, y_write, write_value, re, x_read, y_read, fill_start, fill_value,
        output read_value, read_valid, busy, wr_error
    );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: Width x Height pixel store with registered reads, bounds checks and a fill engine.
//   clk : system clock, all state on rising edge
//   rst : asynchronous active-high reset; starts a clear-to-0 fill
//   bus : frame_buffer_ctrl_if slave (write/read/fill requests, read response, busy, wr_error)
module frame_buffer_ctrl #(
    parameter int Width     = 5,
    parameter int Height    = 10,
    parameter int ColorBits = 3,
    parameter int XBits     = 9,
    parameter int YBits     = 8
) (
    input logic               clk,
    input logic               rst,
    frame_buffer_ctrl_if.slave bus
);
    localparam int Depth   = Width * Height;
    localparam int IdxBits = Depth > 1 ? $clog2(Depth) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t               state_q, state_d;
    logic [IdxBits-1:0]   cnt_q, cnt_d;
    logic [ColorBits-1:0] color_q, color_d;
    logic [ColorBits-1:0] rdata_q, rdata_d;
    logic                 rvalid_q;
    logic                 werr_q, werr_d;
    logic [ColorBits-1:0] mem_q [Depth];

    logic                 busy;
    logic                 last;
    logic                 w_in, r_in;
    logic [IdxBits-1:0]   w_idx, r_idx;
    logic                 mem_we;
    logic [IdxBits-1:0]   mem_idx;
    logic [ColorBits-1:0] mem_wdata;

    assign w_in  = 32'(bus.x_write) < Width && 32'(bus.y_write) < Height;
    assign r_in  = 32'(bus.x_read) < Width && 32'(bus.y_read) < Height;
    // Only meaningful when the coordinate is in range, where it always fits IdxBits.
    assign w_idx = IdxBits'(bus.y_write) * IdxBits'(Width) + IdxBits'(bus.x_write);
    assign r_idx = IdxBits'(bus.y_read) * IdxBits'(Width) + IdxBits'(bus.x_read);
    assign last  = cnt_q == IdxBits'(Depth - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (bus.fill_start ? FILL : IDLE) : (last ? IDLE : FILL);
    end

    always_comb begin
        busy = state_q == FILL;
    end

    // The fill engine owns the single write port while busy; user writes are rejected then.
    always_comb begin
        cnt_d     = busy ? (last ? '0 : cnt_q + 1'b1) : (bus.fill_start ? '0 : cnt_q);
        color_d   = (!busy && bus.fill_start) ? bus.fill_value : color_q;
        mem_we    = busy || (bus.we && w_in);
        mem_idx   = busy ? cnt_q : w_idx;
        mem_wdata = busy ? color_q : bus.write_value;
        werr_d    = bus.we && (!w_in || busy);
        rdata_d   = bus.re ? (r_in ? mem_q[r_idx] : '0) : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            color_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            color_q  <= color_d;
            rdata_q  <= rdata_d;
            rvalid_q <= bus.re;
            werr_q   <= werr_d;
        end
    end

    // Array is not reset; the post-reset fill clears it. Reads sample old data (read-before-write).
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    assign bus.read_value = rdata_q;
    assign bus.read_valid = rvalid_q;
    assign bus.busy       = busy;
    assign bus.wr_error   = werr_q;
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: scoreboard bench for frame_buffer_ctrl with a behavioural pixel-array model.
module tb_frame_buffer_ctrl;
    localparam int W  = 5;
    localparam int H  = 10;
    localparam int CB = 3;
    localparam int XB = 9;
    localparam int YB = 8;
    localparam int D  = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_buffer_ctrl_if #(.XBits(XB), .YBits(YB), .ColorBits(CB)) bus ();

    frame_buffer_ctrl #(.Width(W), .Height(H), .ColorBits(CB), .XBits(XB), .YBits(YB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit rv;
        bit werr;
        bit busy;
    } stat_t;

    stat_t sq[$];
    int    rq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_hold = 0;
    bit    chk_en = 1'b0;

    int    mem[D];
    bit    filling;
    int    pos;
    int    color;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) begin : monitor
        stat_t s;
        int    e;
        #1;
        if (chk_en && !rst) begin
            if (sq.size() == 0) fail("status_underflow");
            else begin
                s = sq.pop_front();
                check("read_valid", int'(bus.read_valid), int'(s.rv));
                check("wr_error", int'(bus.wr_error), int'(s.werr));
                check("busy", int'(bus.busy), int'(s.busy));
            end
            if (bus.read_valid) begin
                if (rq.size() == 0) fail("unexpected_read_valid");
                else begin
                    e = rq.pop_front();
                    check("read_value", int'(bus.read_value), e);
                    exp_hold = e;
                end
            end else check("read_hold", int'(bus.read_value), exp_hold);
        end
    end

    // One clock of the frame buffer's documented behaviour, applied to the current inputs.
    task automatic model_cycle();
        stat_t s;
        bit    win, rin;
        int    xw, yw, xr, yr;
        xw   = int'(bus.x_write);
        yw   = int'(bus.y_write);
        xr   = int'(bus.x_read);
        yr   = int'(bus.y_read);
        win  = xw < W && yw < H;
        rin  = xr < W && yr < H;
        s.rv = bus.re;
        if (bus.re) rq.push_back(rin ? mem[yr * W + xr] : 0);
        s.werr = bus.we && (!win || filling);
        if (bus.we && win && !filling) mem[yw * W + xw] = int'(bus.write_value);
        if (filling) begin
            mem[pos] = color;
            pos++;
            if (pos == D) filling = 1'b0;
        end else if (bus.fill_start) begin
            filling = 1'b1;
            pos     = 0;
            color   = int'(bus.fill_value);
        end
        s.busy = filling;
        sq.push_back(s);
    endtask

    task automatic set_inputs(bit we, int xw, int yw, int wv, bit re, int xr, int yr, bit fs, int fv);
        bus.we          = we;
        bus.x_write     = XB'(xw);
        bus.y_write     = YB'(yw);
        bus.write_value = CB'(wv);
        bus.re          = re;
        bus.x_read      = XB'(xr);
        bus.y_read      = YB'(yr);
        bus.fill_start  = fs;
        bus.fill_value  = CB'(fv);
    endtask

    task automatic drive(bit we, int xw, int yw, int wv, bit re, int xr, int yr, bit fs = 0, int fv = 0);
        @(negedge clk);
        set_inputs(we, xw, yw, wv, re, xr, yr, fs, fv);
        model_cycle();
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_all();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                drive(0, 0, 0, 0, 1, x, y);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_busy", int'(bus.busy), 1);
        check("rst_read_valid", int'(bus.read_valid), 0);
        check("rst_wr_error", int'(bus.wr_error), 0);
        check("rst_read_value", int'(bus.read_value), 0);
        sq.delete();
        rq.delete();
        exp_hold = 0;
        filling  = 1'b1;
        pos      = 0;
        color    = 0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        model_cycle();
    endtask

    initial begin : stim
        bit r_we, r_re, r_fs;
        int r_xw, r_yw, r_xr, r_yr;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) mem[i] = 0;

        do_reset();
        idle(D);
        read_all();

        drive(1, 3, 7, 5, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 7);
        idle(2);

        drive(1, 5, 0, 7, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 10);
        drive(0, 0, 0, 0, 1, 4, 0);
        drive(1, 0, 200, 1, 1, 0, 1);
        idle(1);

        drive(1, 1, 1, 2, 0, 0, 0);
        drive(1, 1, 1, 6, 1, 1, 1);
        drive(0, 0, 0, 0, 1, 1, 1);
        idle(1);

        drive(1, 0, 0, 3, 0, 0, 0, 1, 4);
        for (int i = 1; i < D + 3; i++) begin
            if (i == 10) drive(0, 0, 0, 0, 1, 2, 9, 1, 1);
            else if (i % 7 == 0) drive(1, 2, 2, 7, 1, 4, 9);
            else idle(1);
        end
        read_all();

        drive(0, 0, 0, 0, 0, 0, 0, 1, 6);
        idle(18);
        drive(1, 1, 2, 3, 1, 0, 6);
        do_reset();
        idle(D + 1);
        read_all();

        for (int i = 0; i < 1500; i++) begin
            r_we = $urandom_range(9) < 4;
            r_re = $urandom_range(9) < 5;
            r_fs = $urandom_range(99) < 2;
            r_xw = ($urandom_range(15) == 0) ? int'($urandom_range(511)) : int'($urandom_range(W));
            r_yw = ($urandom_range(15) == 0) ? int'($urandom_range(255)) : int'($urandom_range(H));
            r_xr = ($urandom_range(15) == 0) ? int'($urandom_range(511)) : int'($urandom_range(W));
            r_yr = ($urandom_range(15) == 0) ? int'($urandom_range(255)) : int'($urandom_range(H));
            drive(r_we, r_xw, r_yw, int'($urandom_range(7)), r_re, r_xr, r_yr, r_fs, int'($urandom_range(7)));
        end
        idle(D + 2);
        read_all();
        idle(2);

        @(posedge clk);
        #2;
        check("read_queue_drained", rq.size(), 0);
        check("status_queue_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
